// File: rtl/wp_encode_pkg.sv
// Shared widths and the index-width helper for the one-hot encoder.
package wp_encode_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int OUT_W_DEF = 3;

  // Number of bits needed to hold an index into an in_w-wide vector (at least 1).
  function automatic int idx_width(input int in_w);
    return (in_w <= 2) ? 1 : $clog2(in_w);
  endfunction

endpackage

// File: rtl/wp_onehot_check.sv
// Combinational one-hot detector and index extractor.
module wp_onehot_check
  import wp_encode_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = idx_width(IN_W)
) (
  input  logic [IN_W-1:0]  din_i,
  output logic             is_onehot_o,
  output logic [OUT_W-1:0] index_o
);

  logic [IN_W-1:0] low_clear;

  // Clearing the lowest set bit leaves zero only when at most one bit was set.
  always_comb begin
    low_clear   = din_i & (din_i - IN_W'(1));
    is_onehot_o = (din_i != '0) && (low_clear == '0);
  end

  // OR of every set-bit position: exact for one-hot input, and no bit is favoured.
  always_comb begin
    index_o = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (din_i[i]) index_o = index_o | OUT_W'(i);
    end
  end

endmodule

// File: rtl/wp_encode.sv
// Registered non-priority one-hot encoder with enable, error and sticky error flag.
module wp_encode
  import wp_encode_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  Din,
  input  logic             clr,
  output logic [OUT_W-1:0] Dout,
  output logic             valid,
  output logic             err,
  output logic             err_sticky
);

  logic             rst_sync_q;
  logic             is_onehot;
  logic [OUT_W-1:0] index;

  logic [OUT_W-1:0] dout_d, dout_q;
  logic             valid_d, valid_q;
  logic             err_d, err_q;
  logic             sticky_d, sticky_q;

  // Assertion is immediate; release is retimed to the falling edge so the
  // next rising edge is the first one that updates the outputs.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  wp_onehot_check #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_check (
    .din_i       (Din),
    .is_onehot_o (is_onehot),
    .index_o     (index)
  );

  // en is a disable: high suppresses both the encoding and the error report.
  always_comb begin
    valid_d  = !en && is_onehot;
    err_d    = !en && !is_onehot;
    dout_d   = valid_d ? index : '0;
    sticky_d = err_d | (sticky_q & ~clr);
  end

  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      dout_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  assign Dout       = dout_q;
  assign valid      = valid_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_wp_encode.sv
// Directed self-checking bench for wp_encode.
module tb_wp_encode;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] Din;
  logic       clr;
  logic [2:0] Dout;
  logic       valid;
  logic       err;
  logic       err_sticky;

  int total = 0;
  int bad   = 0;

  wp_encode #(.IN_W(8), .OUT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .Din        (Din),
    .clr        (clr),
    .Dout       (Dout),
    .valid      (valid),
    .err        (err),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [31:0] e_dout,
                      input logic e_valid, input logic e_err, input logic e_sticky);
    chk({tag, ".dout"},   32'(Dout),       e_dout);
    chk({tag, ".valid"},  32'(valid),      32'(e_valid));
    chk({tag, ".err"},    32'(err),        32'(e_err));
    chk({tag, ".sticky"}, 32'(err_sticky), 32'(e_sticky));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    Din   = 8'hFF;
    clr   = 1'b0;

    // Reset applies without a clock edge
    #1 rst_n = 1'b0;
    #2 chk4("rst_immediate", 0, 0, 0, 0);
    tick();
    tick();
    chk4("rst_held", 0, 0, 0, 0);

    // Release: nothing changes until the next rising edge
    rst_n = 1'b1;
    chk4("rst_released", 0, 0, 0, 0);
    tick();
    chk4("first_edge_ff", 0, 0, 1, 1);

    // Clear with a legal input
    clr = 1'b1; Din = 8'h10;
    tick();
    chk4("clr_h10", 4, 1, 0, 0);
    clr = 1'b0;

    // Walking one
    for (int i = 0; i < 8; i++) begin
      Din = 8'(1) << i;
      tick();
      chk4($sformatf("walk%0d", i), i, 1, 0, 0);
    end

    // Disabled
    en = 1'b1; Din = 8'h01;
    tick();
    chk4("dis_h01", 0, 0, 0, 0);
    Din = 8'h40;
    tick();
    chk4("dis_h40", 0, 0, 0, 0);
    en = 1'b0;

    // Invalid inputs
    Din = 8'h00;
    tick();
    chk4("inv_h00", 0, 0, 1, 1);
    Din = 8'h03;
    tick();
    chk4("inv_h03", 0, 0, 1, 1);
    Din = 8'h81;
    tick();
    chk4("inv_h81", 0, 0, 1, 1);

    // Sticky holds across legal input
    Din = 8'h80;
    tick();
    chk4("hold_h80", 7, 1, 0, 1);

    // Set wins over clear
    clr = 1'b1; Din = 8'h11;
    tick();
    chk4("clr_set_h11", 0, 0, 1, 1);
    Din = 8'h20;
    tick();
    chk4("clr_h20", 5, 1, 0, 0);
    clr = 1'b0;

    // Input changes mid-cycle do not reach outputs
    Din = 8'h02;
    #2 chk4("no_comb_path", 5, 1, 0, 0);
    tick();
    chk4("after_h02", 1, 1, 0, 0);

    // Mid-run reset discards the pending sample
    Din = 8'h80;
    #2 rst_n = 1'b0;
    #1 chk4("midrst_immediate", 0, 0, 0, 0);
    tick();
    chk4("midrst_held", 0, 0, 0, 0);
    rst_n = 1'b1;
    chk4("midrst_released", 0, 0, 0, 0);
    tick();
    chk4("midrst_first_edge", 7, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wp_encode.md
WP_ENCODE -- requirements
Module: wp_encode

Interface
REQ-001 Parameter IN_W, default 8: width of the one-hot data input.
REQ-002 Parameter OUT_W, default 3: width of the encoded output; SHALL equal clog2(IN_W).
REQ-003 There SHALL be one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 en  input  1  disable control: 1 = disabled (encoding suppressed), 0 = encode.
REQ-007 Din  input  IN_W  data input, expected one-hot.
REQ-008 clr  input  1  synchronous clear of the sticky error flag.
REQ-009 Dout  output  OUT_W  encoded index of the set bit in Din.
REQ-010 valid  output  1  Dout holds a legal encoding of the previous cycle's input.
REQ-011 err  output  1  previous cycle's enabled input was not one-hot.
REQ-012 err_sticky  output  1  latched OR of err since the last clear or reset.

Function
REQ-013 Non-priority encoder: with en=0 and Din having exactly one bit k set, Dout SHALL become k (Din=8'b00000001 gives 0; Din=8'b10000000 gives 7).
REQ-014 All outputs are registered, with a latency of 1 clk; combinational input changes SHALL NOT reach the outputs before the next rising edge.
REQ-015 On the edge after sampling en=0 with a one-hot Din: Dout=k, valid=1, err=0.
REQ-016 On the edge after sampling en=0 with a non-one-hot Din (zero bits set or two or more bits set): Dout=0, valid=0, err=1; no bit is preferred over another.
REQ-017 On the edge after sampling en=1: Dout=0, valid=0, err=0, regardless of Din.
REQ-018 err_sticky SHALL set on the same edge that err is set, and SHALL hold until cleared.
REQ-019 clr=1 SHALL clear err_sticky on the next edge; if err is being set on that same edge, set wins and err_sticky stays 1.
REQ-020 One-hot detection SHALL work for any IN_W that is a power of two, 2 to 64.

Reset
REQ-021 While rst_n=0: Dout=0, valid=0, err=0, err_sticky=0, applied immediately without waiting for clk.
REQ-022 Reset deassertion SHALL be synchronised to clk inside the block; the first output update occurs on the first edge after deassertion.
REQ-023 Reset asserted mid-operation SHALL discard the pending sample; no stale value SHALL appear after release.

Structure
REQ-024 A shared package SHALL hold IN_W_DEF=8, OUT_W_DEF=3, and a function computing the index width from IN_W.
REQ-025 One sub-module, wp_onehot_check, SHALL be used: it is combinational, takes Din, and returns is_onehot and index; the top level adds the enable logic, registers, sticky error flag and reset synchroniser.

Verification
REQ-026 Reset: rst_n=0 with Din=8'hFF and en=0 -> all outputs 0 immediately; they stay 0 until the first edge after release.
REQ-027 Walking one: en=0, Din=8'h01, 02, 04, ... 80, one per cycle -> Dout=0..7 respectively one cycle later, with valid=1 and err=0 each time.
REQ-028 Disable: en=1 with Din=8'h01, then Din=8'h40 -> Dout=0, valid=0, err=0 for both.
REQ-029 Invalid input: en=0 with Din=8'h00, then Din=8'h03 -> Dout=0, valid=0, err=1 each time, and err_sticky=1 from the first of them.
REQ-030 Sticky clear: err_sticky=1, then clr=1 with Din=8'h10 -> err_sticky=0 and Dout=4; then clr=1 with Din=8'h11 -> err_sticky stays 1.
REQ-031 Mid-run reset: Din=8'h80 applied, rst_n pulsed low before the edge -> Dout=0 and valid=0; Dout=7 appears only after the first edge following release.
